gen3_scrambler_multilane: RTL and testbench

//  Multi-lane 128b/130b scrambler for the Gen3+ TX/RX datapath. One G(X)=X^23+X^21+X^16+X^8+X^5+X^2+1

---
 rtl/gen3_scr_pkg.sv | 46 ++++
 rtl/gen3_scr_lane.sv | 33 +++
 rtl/gen3_scrambler_multilane.sv | 115 +++++++++++
 tb/tb_gen3_scrambler_multilane.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen3_scr_pkg.sv
// Shared constants and the Galois LFSR step used by every scrambler lane.
// G(X) = X^23 + X^21 + X^16 + X^8 + X^5 + X^2 + 1; the serial output is bit 22.
package gen3_scr_pkg;

  localparam int LFSR_W = 23;
  localparam int KS_MAX = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h210125;

  localparam logic [LFSR_W-1:0] SEED [0:7] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;
  localparam logic [7:0] SYM_SKP   = 8'hAA;
  localparam logic [7:0] SYM_EIEOS = 8'h00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_OS    = 3'd2;
  localparam logic [2:0] ST_SKP   = 3'd3;
  localparam logic [2:0] ST_EIEOS = 3'd4;

  typedef struct packed {
    logic [LFSR_W-1:0] next_state;
    logic [KS_MAX-1:0] keystream;
  } lfsr_res_t;

  // Keystream bit i is the serial output after i shifts; bits at or above nbits stay zero.
  function automatic lfsr_res_t lfsr_adv(input logic [LFSR_W-1:0] state, input int nbits);
    lfsr_res_t         res;
    logic [LFSR_W-1:0] s;
    s = state;
    res.keystream = '0;
    for (int i = 0; i < KS_MAX; i++) begin
      if (i < nbits) begin
        res.keystream[i] = s[LFSR_W-1];
        s = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_TAPS : '0);
      end
    end
    res.next_state = s;
    return res;
  endfunction

endpackage

// File: rtl/gen3_scr_lane.sv
// One lane: LFSR register advanced DATA_WIDTH shifts per beat, reseedable, with optional XOR.
module gen3_scr_lane
  import gen3_scr_pkg::*;
#(
  parameter int                DATA_WIDTH = 32,
  parameter logic [LFSR_W-1:0] SEED_VAL   = 23'h1DBFBC
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  load_seed,
  input  logic                  adv,
  input  logic                  xor_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [LFSR_W-1:0] lfsr;
  lfsr_res_t         adv_res;
  logic              unused_ks;

  assign adv_res   = lfsr_adv(lfsr, DATA_WIDTH);
  assign unused_ks = ^adv_res.keystream;
  assign dout      = xor_en ? (din ^ adv_res.keystream[DATA_WIDTH-1:0]) : din;

  always_ff @(posedge pclk) begin
    if (reset || load_seed) begin
      lfsr <= SEED_VAL;
    end else if (adv) begin
      lfsr <= adv_res.next_state;
    end
  end

endmodule

// File: rtl/gen3_scrambler_multilane.sv
// Multi-lane 128b/130b scrambler / descrambler: block-type FSM, beat counter and
// one registered output stage in front of per-lane LFSRs.
module gen3_scrambler_multilane
  import gen3_scr_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        pclk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                  in_sync_hdr,
  input  logic                        in_block_start,
  input  logic                        bypass,
  output logic                        out_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [1:0]                  out_sync_hdr,
  output logic                        out_block_start,
  output logic                        align_err
);

  localparam int BEATS = 128 / DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  logic [2:0]                  state;
  logic [2:0]                  blk_type;
  logic [2:0]                  cur_type;
  logic [CNT_W-1:0]            beat_cnt;
  logic [CNT_W-1:0]            eff_cnt;
  logic                        viol;
  logic                        last_beat;
  logic                        lane_load;
  logic                        lane_adv;
  logic                        lane_xor;
  logic [LANES*DATA_WIDTH-1:0] lane_dout;

  // Block type implied by this beat's header, used only when it opens a block.
  always_comb begin
    blk_type = ST_IDLE;
    if (in_sync_hdr == SYNC_DATA) begin
      blk_type = ST_DATA;
    end else if (in_sync_hdr == SYNC_OS) begin
      if (in_data[7:0] == SYM_SKP)        blk_type = ST_SKP;
      else if (in_data[7:0] == SYM_EIEOS) blk_type = ST_EIEOS;
      else                                blk_type = ST_OS;
    end
  end

  // A misplaced block start is still honoured; a missing one drops to clear pass-through.
  always_comb begin
    cur_type = state;
    eff_cnt  = beat_cnt;
    viol     = 1'b0;
    if (in_block_start) begin
      cur_type = blk_type;
      eff_cnt  = '0;
      viol     = (beat_cnt != '0) || (blk_type == ST_IDLE);
    end else if (beat_cnt == '0) begin
      cur_type = ST_IDLE;
      viol     = 1'b1;
    end
  end

  assign last_beat = (eff_cnt == CNT_W'(BEATS - 1));
  assign lane_load = in_valid && (cur_type == ST_EIEOS) && last_beat;
  assign lane_adv  = in_valid && !lane_load &&
                     ((cur_type == ST_DATA) || (cur_type == ST_OS) || (cur_type == ST_EIEOS));
  assign lane_xor  = (cur_type == ST_DATA) && !bypass;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gen3_scr_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEED_VAL   (SEED[l % 8])
    ) u_lane (
      .pclk      (pclk),
      .reset     (reset),
      .load_seed (lane_load),
      .adv       (lane_adv),
      .xor_en    (lane_xor),
      .din       (in_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .dout      (lane_dout[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else if (in_valid) begin
      state    <= cur_type;
      beat_cnt <= last_beat ? '0 : eff_cnt + CNT_W'(1);
    end
  end

  // Output register stage: one pclk from in_* to out_*.
  always_ff @(posedge pclk) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_sync_hdr    <= 2'b00;
      out_block_start <= 1'b0;
      align_err       <= 1'b0;
    end else begin
      out_valid       <= in_valid;
      out_block_start <= in_valid && in_block_start;
      align_err       <= in_valid && viol;
      if (in_valid) begin
        out_data     <= lane_dout;
        out_sync_hdr <= in_sync_hdr;
      end
    end
  end

endmodule

// File: tb/tb_gen3_scrambler_multilane.sv
// Bench for gen3_scrambler_multilane: block-level reference model, table of block
// vectors, boundary/reset sequences, and a chained descrambler round trip.
module tb_gen3_scrambler_multilane;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int W     = LANES * DW;
  localparam int BEATS = 128 / DW;

  localparam int K_IDLE  = 0;
  localparam int K_DATA  = 1;
  localparam int K_OS    = 2;
  localparam int K_SKP   = 3;
  localparam int K_EIEOS = 4;

  logic         pclk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_sync_hdr = 2'b00;
  logic         in_block_start = 1'b0;
  logic         bypass = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sync_hdr;
  logic         out_block_start;
  logic         align_err;
  logic         ds_out_valid;
  logic [W-1:0] ds_out_data;
  logic [1:0]   ds_out_sync_hdr;
  logic         ds_out_block_start;
  logic         ds_align_err;

  always #5 pclk = ~pclk;

  gen3_scrambler_multilane #(.LANES(LANES), .DATA_WIDTH(DW)) dut (
    .pclk(pclk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sync_hdr(in_sync_hdr), .in_block_start(in_block_start), .bypass(bypass),
    .out_valid(out_valid), .out_data(out_data), .out_sync_hdr(out_sync_hdr),
    .out_block_start(out_block_start), .align_err(align_err)
  );

  gen3_scrambler_multilane #(.LANES(LANES), .DATA_WIDTH(DW)) u_descr (
    .pclk(pclk), .reset(reset), .in_valid(out_valid), .in_data(out_data),
    .in_sync_hdr(out_sync_hdr), .in_block_start(out_block_start), .bypass(1'b0),
    .out_valid(ds_out_valid), .out_data(ds_out_data), .out_sync_hdr(ds_out_sync_hdr),
    .out_block_start(ds_out_block_start), .align_err(ds_align_err)
  );

  int checks = 0;
  int errors = 0;

  bit [22:0] seeds [8] = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
                           23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
  bit [22:0] tap_mask;
  bit [22:0] ml [LANES];
  bit        chain_en = 1'b0;
  bit        prev_v = 1'b0;
  bit [W-1:0] prev_d = '0;
  bit [W-1:0] first_out;

  typedef struct {
    bit [1:0] sh;
    bit [7:0] sym0;
    bit       byp;
    int       kind;
    bit       err;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Polynomial G(X) as a feedback mask built from its exponents (X^23 is the shift-out).
  function automatic bit [22:0] poly_mask();
    int ex [6] = '{21, 16, 8, 5, 2, 0};
    bit [22:0] m = '0;
    foreach (ex[i]) m[ex[i]] = 1'b1;
    return m;
  endfunction

  function automatic bit [22:0] shift1(input bit [22:0] s);
    return {s[21:0], 1'b0} ^ (s[22] ? tap_mask : 23'h0);
  endfunction

  function automatic bit [31:0] serial_bits(input bit [22:0] s0);
    bit [22:0] s = s0;
    bit [31:0] ks;
    for (int i = 0; i < DW; i++) begin
      ks[i] = s[22];
      s = shift1(s);
    end
    return ks;
  endfunction

  task automatic model_ks(input int l, output bit [31:0] ks);
    ks = serial_bits(ml[l]);
    for (int i = 0; i < DW; i++) ml[l] = shift1(ml[l]);
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) ml[l] = seeds[l % 8];
  endtask

  task automatic drive(input bit v, input bit [W-1:0] d, input bit [1:0] sh,
                       input bit bs, input bit byp);
    in_valid = v; in_data = d; in_sync_hdr = sh; in_block_start = bs; bypass = byp;
    @(posedge pclk); #1;
    if (chain_en) begin
      chk("chain_valid", W'(ds_out_valid), W'(prev_v));
      if (prev_v) chk("chain_data", ds_out_data, prev_d);
    end
    prev_v = v;
    prev_d = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, 2'b00, 0, 0);
    drive(0, '0, 2'b00, 0, 0);
    reset = 1'b0;
    prev_v = 1'b0;
    model_reset();
  endtask

  // Sends one block (or its first nbeats) and checks every beat against the block model.
  task automatic send_block(input int kind, input bit [1:0] sh, input bit [7:0] sym0,
                            input int dmode, input int bmode, input int gap_max,
                            input bit first_bs, input int nbeats, input bit exp_err);
    for (int b = 0; b < nbeats; b++) begin
      bit [W-1:0] d;
      bit [W-1:0] exp;
      bit [31:0]  ks;
      bit         byp;
      bit         bs;
      int         gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) begin
        drive(0, {$urandom, $urandom, $urandom, $urandom}, sh, 0, 0);
        chk("gap_valid", W'(out_valid), W'(0));
        chk("gap_err", W'(align_err), W'(0));
      end
      d = (dmode != 0) ? {$urandom, $urandom, $urandom, $urandom} : '0;
      if (b == 0) d[7:0] = sym0;
      byp = (bmode == 1) ? 1'b1 : ((bmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      bs = (b == 0) && first_bs;
      exp = d;
      for (int l = 0; l < LANES; l++) begin
        case (kind)
          K_DATA: begin
            model_ks(l, ks);
            if (!byp) exp[l*DW +: DW] = d[l*DW +: DW] ^ ks;
          end
          K_OS: model_ks(l, ks);
          K_EIEOS: begin
            if (b == BEATS - 1) ml[l] = seeds[l % 8];
            else model_ks(l, ks);
          end
          default: ;
        endcase
      end
      drive(1, d, sh, bs, byp);
      chk($sformatf("valid k%0d b%0d", kind, b), W'(out_valid), W'(1));
      chk($sformatf("data k%0d b%0d", kind, b), out_data, exp);
      chk($sformatf("err k%0d b%0d", kind, b), W'(align_err), W'((b == 0) ? exp_err : 1'b0));
      chk($sformatf("bstart k%0d b%0d", kind, b), W'(out_block_start), W'(bs));
      chk($sformatf("sync k%0d b%0d", kind, b), W'(out_sync_hdr), W'(sh));
      if (b == 0) first_out = out_data;
    end
  endtask

  function automatic bit [7:0] os_sym();
    bit [7:0] s;
    do s = 8'($urandom); while (s == 8'hAA || s == 8'h00);
    return s;
  endfunction

  initial begin
    bit [W-1:0] seed_beat0;
    bit [W-1:0] t1_beat0;
    bit [W-1:0] no_skp;
    bit [22:0]  saved [LANES];

    tap_mask = poly_mask();
    for (int l = 0; l < LANES; l++) seed_beat0[l*DW +: DW] = serial_bits(seeds[l % 8]);

    tbl[0] = '{sh: 2'b10, sym0: 8'h00, byp: 1'b0, kind: K_DATA,  err: 1'b0};
    tbl[1] = '{sh: 2'b01, sym0: 8'h55, byp: 1'b0, kind: K_OS,    err: 1'b0};
    tbl[2] = '{sh: 2'b01, sym0: 8'hAA, byp: 1'b0, kind: K_SKP,   err: 1'b0};
    tbl[3] = '{sh: 2'b10, sym0: 8'hAA, byp: 1'b0, kind: K_DATA,  err: 1'b0};
    tbl[4] = '{sh: 2'b01, sym0: 8'h00, byp: 1'b0, kind: K_EIEOS, err: 1'b0};
    tbl[5] = '{sh: 2'b10, sym0: 8'h12, byp: 1'b1, kind: K_DATA,  err: 1'b0};
    tbl[6] = '{sh: 2'b11, sym0: 8'h00, byp: 1'b0, kind: K_IDLE,  err: 1'b1};
    tbl[7] = '{sh: 2'b10, sym0: 8'h34, byp: 1'b0, kind: K_DATA,  err: 1'b0};
    tbl[8] = '{sh: 2'b00, sym0: 8'h56, byp: 1'b0, kind: K_IDLE,  err: 1'b1};
    tbl[9] = '{sh: 2'b10, sym0: 8'h78, byp: 1'b0, kind: K_DATA,  err: 1'b0};

    // Reset values and golden keystream of a zero DATA block.
    do_reset();
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_data", out_data, '0);
    chk("rst_sync", W'(out_sync_hdr), W'(0));
    chk("rst_bstart", W'(out_block_start), W'(0));
    chk("rst_err", W'(align_err), W'(0));
    send_block(K_DATA, 2'b10, 8'h00, 0, 0, 0, 1, BEATS, 0);
    t1_beat0 = first_out;
    chk("t1_seed_ks", t1_beat0, seed_beat0);

    // Table of block vectors.
    foreach (tbl[i])
      send_block(tbl[i].kind, tbl[i].sh, tbl[i].sym0, 1, tbl[i].byp ? 1 : 0, 0, 1, BEATS, tbl[i].err);

    // DATA, SKP, DATA: keystream must continue as if SKP were absent.
    do_reset();
    send_block(K_DATA, 2'b10, 8'h11, 1, 0, 0, 1, BEATS, 0);
    saved = ml;
    for (int l = 0; l < LANES; l++) no_skp[l*DW +: DW] = serial_bits(saved[l]);
    send_block(K_SKP, 2'b01, 8'hAA, 1, 2, 0, 1, BEATS, 0);
    send_block(K_DATA, 2'b10, 8'h00, 0, 0, 0, 1, BEATS, 0);
    chk("skp_hold_ks", first_out, no_skp);

    // EIEOS reseeds all lanes.
    send_block(K_EIEOS, 2'b01, 8'h00, 1, 0, 0, 1, BEATS, 0);
    send_block(K_DATA, 2'b10, 8'h00, 0, 0, 0, 1, BEATS, 0);
    chk("eieos_reseed", first_out, t1_beat0);

    // Block start on beat 2, then missing block start.
    send_block(K_DATA, 2'b10, 8'h21, 1, 0, 0, 1, 2, 0);
    send_block(K_DATA, 2'b10, 8'h22, 1, 0, 0, 1, BEATS, 1);
    send_block(K_DATA, 2'b10, 8'h23, 1, 0, 0, 1, BEATS, 0);
    send_block(K_IDLE, 2'b10, 8'h24, 1, 0, 0, 0, BEATS, 1);
    send_block(K_DATA, 2'b10, 8'h25, 1, 0, 0, 1, BEATS, 0);

    // Gaps inside blocks.
    send_block(K_DATA, 2'b10, 8'h31, 1, 0, 3, 1, BEATS, 0);
    send_block(K_OS, 2'b01, 8'h32, 1, 0, 3, 1, BEATS, 0);
    send_block(K_DATA, 2'b10, 8'h33, 1, 2, 3, 1, BEATS, 0);

    // Reset on beat 1 of a block.
    send_block(K_DATA, 2'b10, 8'h41, 1, 0, 0, 1, 1, 0);
    reset = 1'b1;
    drive(1, {$urandom, $urandom, $urandom, $urandom}, 2'b10, 0, 0);
    reset = 1'b0;
    model_reset();
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_data", out_data, '0);
    chk("midrst_sync", W'(out_sync_hdr), W'(0));
    chk("midrst_bstart", W'(out_block_start), W'(0));
    chk("midrst_err", W'(align_err), W'(0));
    send_block(K_DATA, 2'b10, 8'h00, 0, 0, 0, 1, BEATS, 0);
    chk("midrst_seed_ks", first_out, t1_beat0);

    // Random block mix against the model.
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(1, 4));
      case (k)
        K_DATA:  send_block(K_DATA, 2'b10, 8'($urandom), 1, 2, 2, 1, BEATS, 0);
        K_OS:    send_block(K_OS, 2'b01, os_sym(), 1, 2, 2, 1, BEATS, 0);
        K_SKP:   send_block(K_SKP, 2'b01, 8'hAA, 1, 2, 2, 1, BEATS, 0);
        default: send_block(K_EIEOS, 2'b01, 8'h00, 1, 2, 2, 1, BEATS, 0);
      endcase
    end

    // Scrambler into descrambler round trip.
    do_reset();
    chain_en = 1'b1;
    for (int n = 0; n < 12; n++)
      send_block(K_DATA, 2'b10, 8'($urandom), 1, 0, 1, 1, BEATS, 0);
    drive(0, '0, 2'b00, 0, 0);
    drive(0, '0, 2'b00, 0, 0);
    chain_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
